large_matrix_mult: RTL and testbench

//  Streaming unsigned integer matrix multiplier C = A x B for square MATRIX_WIDTH x MATRIX_WIDTH matrices.

---
 rtl/large_matrix_mult.sv | 143 ++++++++++++++
 tb/tb_large_matrix_mult.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/large_matrix_mult.sv
`default_nettype none
// ============================================================================
// Module      : large_matrix_mult
// Description : Streaming unsigned N x N matrix multiplier C = A x B. Rows of A
//               then B arrive one per beat; rows of C leave under write_en.
//               Define LMM_SATURATE_EN to saturate result elements instead of
//               truncating them modulo 2^WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module large_matrix_mult #(
    parameter int WIDTH        = 8,
    parameter int NUM_ELEMENTS = 4,
    parameter int MATRIX_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [NUM_ELEMENTS*WIDTH-1:0] Res,
    input  logic [NUM_ELEMENTS*WIDTH-1:0] rdata,
    input  logic                          read_en,
    input  logic                          write_en,
    output logic                          write_ready
);

    localparam int N     = MATRIX_WIDTH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = 2*WIDTH + ((N > 1) ? $clog2(N) : 0);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N-1);
`ifdef LMM_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_LIMIT = {{(ACC_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};
`endif

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] k;

    logic [WIDTH-1:0] a_mat [N][N];
    logic [WIDTH-1:0] b_mat [N][N];
    logic [ACC_W-1:0] c_mat [N][N];

    logic [ACC_W-1:0]              prod [N];
    logic [NUM_ELEMENTS*WIDTH-1:0] res_row;

    // One multiplier per output column; row doubles as the i index in COMPUTE
    // and as the output row index in WRITE.
    always_comb begin
        res_row = '0;
        for (int j = 0; j < N; j++) begin
            prod[j] = ACC_W'(a_mat[row][k]) * ACC_W'(b_mat[k][j]);
`ifdef LMM_SATURATE_EN
            res_row[j*WIDTH +: WIDTH] = (c_mat[row][j] > SAT_LIMIT) ? {WIDTH{1'b1}}
                                                                    : c_mat[row][j][WIDTH-1:0];
`else
            res_row[j*WIDTH +: WIDTH] = c_mat[row][j][WIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= LOAD_A;
            row         <= '0;
            k           <= '0;
            Res         <= '0;
            write_ready <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_mat[i][j] <= '0;
                    b_mat[i][j] <= '0;
                    c_mat[i][j] <= '0;
                end
            end
        end else begin
            case (state)
                LOAD_A: begin
                    if (read_en) begin
                        for (int j = 0; j < N; j++)
                            a_mat[row][j] <= rdata[j*WIDTH +: WIDTH];
                        if (row == LAST) begin
                            row   <= '0;
                            state <= LOAD_B;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (read_en) begin
                        for (int j = 0; j < N; j++)
                            b_mat[row][j] <= rdata[j*WIDTH +: WIDTH];
                        if (row == LAST) begin
                            row   <= '0;
                            k     <= '0;
                            state <= COMPUTE;
                            for (int i = 0; i < N; i++)
                                for (int j = 0; j < N; j++)
                                    c_mat[i][j] <= '0;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    for (int j = 0; j < N; j++)
                        c_mat[row][j] <= c_mat[row][j] + prod[j];
                    if (k == LAST) begin
                        k <= '0;
                        if (row == LAST) begin
                            row         <= '0;
                            state       <= WRITE;
                            write_ready <= 1'b1;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                WRITE: begin
                    if (write_ready && write_en) begin
                        Res <= res_row;
                        if (row == LAST) begin
                            row         <= '0;
                            write_ready <= 1'b0;
                            state       <= LOAD_A;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_large_matrix_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_large_matrix_mult
// Description : Scoreboard bench for large_matrix_mult; expected rows come from
//               a behavioural model queued at stimulus time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_large_matrix_mult;

    localparam int W = 8;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*W-1:0]  Res;
    logic [N*W-1:0]  rdata;
    logic            read_en;
    logic            write_en;
    logic            write_ready;

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [N*W-1:0]  ja [N];
    logic [N*W-1:0]  jb [N];
    logic [N*W-1:0]  sb [$];
    logic [N*W-1:0]  last_res;

    large_matrix_mult #(.WIDTH(W), .NUM_ELEMENTS(N), .MATRIX_WIDTH(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .Res         (Res),
        .rdata       (rdata),
        .read_en     (read_en),
        .write_en    (write_en),
        .write_ready (write_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] model_row(input int i);
        logic [N*W-1:0] r;
        longint         acc;
        r = '0;
        for (int j = 0; j < N; j++) begin
            acc = 0;
            for (int kk = 0; kk < N; kk++)
                acc += longint'(ja[i][kk*W +: W]) * longint'(jb[kk][j*W +: W]);
`ifdef LMM_SATURATE_EN
            r[j*W +: W] = (acc > 255) ? 8'hFF : acc[7:0];
`else
            r[j*W +: W] = acc[7:0];
`endif
        end
        return r;
    endfunction

    task automatic push_expected();
        for (int i = 0; i < N; i++) sb.push_back(model_row(i));
    endtask

    task automatic pop_check(input string tag);
        logic [N*W-1:0] e;
        check({tag, "_pending"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check(tag, Res, e);
        end
        last_res = Res;
    endtask

    task automatic load_job(input bit do_push);
        if (do_push) push_expected();
        for (int r = 0; r < 2*N; r++) begin
            rdata   = (r < N) ? ja[r] : jb[r-N];
            read_en = 1'b1;
            @(posedge clk); #1;
        end
        read_en = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int cnt = 0;
        while (!write_ready && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        check(tag, 32'(cnt), 32'd16);
    endtask

    task automatic drain(input string tag);
        for (int r = 0; r < N; r++) begin
            check({tag, "_ready"}, 32'(write_ready), 32'd1);
            write_en = 1'b1;
            @(posedge clk); #1;
            write_en = 1'b0;
            pop_check($sformatf("%s_row%0d", tag, r));
        end
        check({tag, "_ready_low"}, 32'(write_ready), 32'd0);
    endtask

    task automatic set_identity_job();
        ja[0] = 32'h0000_0001; ja[1] = 32'h0000_0100;
        ja[2] = 32'h0001_0000; ja[3] = 32'h0100_0000;
        jb[0] = 32'h0403_0201; jb[1] = 32'h0807_0605;
        jb[2] = 32'h0C0B_0A09; jb[3] = 32'h100F_0E0D;
    endtask

    task automatic set_random_job();
        for (int i = 0; i < N; i++) begin
            ja[i] = $urandom;
            jb[i] = $urandom;
        end
    endtask

    initial begin
        int cnt;
        reset = 1'b1; read_en = 1'b0; write_en = 1'b0; rdata = '0; last_res = '0;
        #2;
        check("rst_res", Res, 32'd0);
        check("rst_ready", 32'(write_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Both enables held high with a constant operand row
        for (int i = 0; i < N; i++) begin ja[i] = 32'h1; jb[i] = 32'h1; end
        push_expected();
        read_en = 1'b1; write_en = 1'b1; rdata = 32'h0000_0001;
        cnt = 0;
        while (!write_ready && cnt < 60) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("stream_latency", 32'(cnt), 32'd24);
        for (int r = 0; r < N; r++) begin
            @(posedge clk); #1;
            pop_check($sformatf("stream_row%0d", r));
        end
        check("stream_ready_low", 32'(write_ready), 32'd0);
        read_en = 1'b0; write_en = 1'b0;

        set_identity_job();
        load_job(1'b1);
        wait_ready("ident_latency");
        drain("ident");

        // Stall readout while read_en toggles with junk data
        set_random_job();
        load_job(1'b1);
        wait_ready("stall_latency");
        for (int c = 0; c < 5; c++) begin
            read_en = c[0];
            rdata   = $urandom;
            @(posedge clk); #1;
            check($sformatf("stall_res%0d", c), Res, last_res);
            check($sformatf("stall_ready%0d", c), 32'(write_ready), 32'd1);
        end
        read_en = 1'b0;
        drain("stall");

        for (int i = 0; i < N; i++) begin ja[i] = 32'hFFFF_FFFF; jb[i] = 32'hFFFF_FFFF; end
        load_job(1'b1);
        wait_ready("ff_latency");
        drain("ff");

        // Asynchronous reset mid-clock while results are pending
        set_random_job();
        load_job(1'b0);
        wait_ready("pre_rst_latency");
        #3 reset = 1'b1;
        #1;
        check("async_rst_res", Res, 32'd0);
        check("async_rst_ready", 32'(write_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Abort a job during COMPUTE, then rerun a clean job
        set_random_job();
        load_job(1'b0);
        repeat (5) begin @(posedge clk); #1; end
        #3 reset = 1'b1;
        #1;
        check("abort_ready", 32'(write_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        set_identity_job();
        load_job(1'b1);
        wait_ready("rerun_latency");
        drain("rerun");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
